// File: rtl/cache_sdram_arbiter.sv
// Arbiter sharing one SDRAM controller port between two cache fill requesters
// and the CPU write-through path: burst fills for reads, masked single-word writes.
module cache_sdram_arbiter #(
    parameter int BURST_LEN = 8,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              c0_req,
    input  logic [ADDR_W-1:0] c0_addr,
    output logic              c0_fill,
    input  logic              c1_req,
    input  logic [ADDR_W-1:0] c1_addr,
    output logic              c1_fill,
    output logic [15:0]       rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    input  logic              wr_uds_n,
    input  logic              wr_lds_n,
    output logic              wr_ack,
    output logic              sd_req,
    output logic              sd_we,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [15:0]       sd_wdata,
    output logic              sd_uds_n,
    output logic              sd_lds_n,
    input  logic              sd_ack,
    input  logic              sd_rdvalid,
    input  logic [15:0]       sd_rdata
);

    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]    state;
    logic          wprio;
    logic          last_rd;
    logic          client;
    logic [CW-1:0] cnt;

    logic rd_pend;
    logic wr_win;
    logic rd_pick;

    // rd_pick: 1 selects c1; on contention the cache not served last wins
    always_comb begin
        rd_pend = c0_req | c1_req;
        wr_win  = wr_req & (wprio | ~rd_pend);
        rd_pick = (c0_req & c1_req) ? ~last_rd : c1_req;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            wprio    <= 1'b1;
            last_rd  <= 1'b1;
            client   <= 1'b0;
            cnt      <= '0;
            sd_req   <= 1'b0;
            sd_we    <= 1'b0;
            sd_addr  <= '0;
            sd_wdata <= '0;
            sd_uds_n <= 1'b1;
            sd_lds_n <= 1'b1;
            c0_fill  <= 1'b0;
            c1_fill  <= 1'b0;
            wr_ack   <= 1'b0;
            rd_data  <= '0;
        end else begin
            c0_fill <= 1'b0;
            c1_fill <= 1'b0;
            wr_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_win) begin
                        state    <= WR_REQ;
                        sd_req   <= 1'b1;
                        sd_we    <= 1'b1;
                        sd_addr  <= wr_addr;
                        sd_wdata <= wr_data;
                        sd_uds_n <= wr_uds_n;
                        sd_lds_n <= wr_lds_n;
                    end else if (rd_pend) begin
                        state   <= RD_REQ;
                        sd_req  <= 1'b1;
                        sd_we   <= 1'b0;
                        sd_addr <= rd_pick ? c1_addr : c0_addr;
                        client  <= rd_pick;
                        last_rd <= rd_pick;
                    end
                end
                RD_REQ: begin
                    if (sd_ack) begin
                        sd_req <= 1'b0;
                        cnt    <= '0;
                        state  <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (sd_rdvalid) begin
                        rd_data <= sd_rdata;
                        cnt     <= cnt + 1'b1;
                        if (cnt == '0) begin
                            c0_fill <= ~client;
                            c1_fill <= client;
                        end
                        // cnt wraps back to zero on the last word
                        if (cnt == CW'(BURST_LEN - 1)) begin
                            state <= DONE;
                            wprio <= 1'b1;
                        end
                    end
                end
                WR_REQ: begin
                    if (sd_ack) begin
                        sd_req <= 1'b0;
                        wr_ack <= 1'b1;
                        wprio  <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_sdram_arbiter.sv
// Directed bench for cache_sdram_arbiter: a per-cycle vector table for a basic
// fill plus hand sequences for round-robin, write priority and mid-burst reset.
module tb_cache_sdram_arbiter;

    localparam int BL = 8;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          c0_req, c1_req, wr_req;
    logic [AW-1:0] c0_addr, c1_addr, wr_addr;
    logic          c0_fill, c1_fill;
    logic [15:0]   rd_data, wr_data, sd_wdata, sd_rdata;
    logic          wr_uds_n, wr_lds_n, wr_ack;
    logic          sd_req, sd_we, sd_uds_n, sd_lds_n, sd_ack, sd_rdvalid;
    logic [AW-1:0] sd_addr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cache_sdram_arbiter #(.BURST_LEN(BL), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .c0_req(c0_req), .c0_addr(c0_addr), .c0_fill(c0_fill),
        .c1_req(c1_req), .c1_addr(c1_addr), .c1_fill(c1_fill),
        .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_uds_n(wr_uds_n), .wr_lds_n(wr_lds_n), .wr_ack(wr_ack),
        .sd_req(sd_req), .sd_we(sd_we), .sd_addr(sd_addr), .sd_wdata(sd_wdata),
        .sd_uds_n(sd_uds_n), .sd_lds_n(sd_lds_n),
        .sd_ack(sd_ack), .sd_rdvalid(sd_rdvalid), .sd_rdata(sd_rdata)
    );

    // in = {reset_n, c0_req, c1_req, wr_req, sd_ack, sd_rdvalid}
    // ex = {sd_req, sd_we, c0_fill, c1_fill, wr_ack}
    typedef struct {
        logic [5:0]    in;
        logic [15:0]   rdata;
        logic [4:0]    ex;
        logic [15:0]   erd;
        logic          chka;
        logic [AW-1:0] eaddr;
    } vec_t;

    vec_t tbl[17];

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_sd_req"}, sd_req, 1'b0);
        chk1({tag, "_sd_we"}, sd_we, 1'b0);
        chk32({tag, "_sd_addr"}, sd_addr, 32'h0);
        chk16({tag, "_sd_wdata"}, sd_wdata, 16'h0);
        chk1({tag, "_sd_uds_n"}, sd_uds_n, 1'b1);
        chk1({tag, "_sd_lds_n"}, sd_lds_n, 1'b1);
        chk1({tag, "_c0_fill"}, c0_fill, 1'b0);
        chk1({tag, "_c1_fill"}, c1_fill, 1'b0);
        chk1({tag, "_wr_ack"}, wr_ack, 1'b0);
        chk16({tag, "_rd_data"}, rd_data, 16'h0);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (sd_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk1(name, sd_req, 1'b1);
    endtask

    // Full burst serving; the granted cache drops its request on its fill strobe
    task automatic serve_read(input logic cl, input logic [AW-1:0] a, input logic [15:0] base);
        wait_req("rd_grant");
        chk1("rd_we", sd_we, 1'b0);
        chk32("rd_addr", sd_addr, a);
        sd_ack = 1'b1;
        step();
        sd_ack = 1'b0;
        chk1("rd_req_drop", sd_req, 1'b0);
        for (int i = 0; i < BL; i++) begin
            sd_rdvalid = 1'b1;
            sd_rdata   = base + 16'(i);
            step();
            chk1("rd_c0_fill", c0_fill, (cl == 1'b0) && (i == 0));
            chk1("rd_c1_fill", c1_fill, (cl == 1'b1) && (i == 0));
            chk16("rd_data", rd_data, base + 16'(i));
            if (i == 0) begin
                if (cl) c1_req = 1'b0;
                else    c0_req = 1'b0;
            end
        end
        sd_rdvalid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; c0_req = 1'b0; c1_req = 1'b0; wr_req = 1'b0;
        c0_addr = 32'h1236; c1_addr = 32'h2468; wr_addr = 32'h0;
        wr_data = 16'h0; wr_uds_n = 1'b1; wr_lds_n = 1'b1;
        sd_ack = 1'b0; sd_rdvalid = 1'b0; sd_rdata = 16'h0;

        tbl[0]  = '{6'b100011, 16'hDEAD, 5'b00000, 16'h0000, 1'b0, 32'h0};
        tbl[1]  = '{6'b100011, 16'hBEEF, 5'b00000, 16'h0000, 1'b0, 32'h0};
        tbl[2]  = '{6'b110000, 16'h0000, 5'b10000, 16'h0000, 1'b1, 32'h1236};
        tbl[3]  = '{6'b110000, 16'h0000, 5'b10000, 16'h0000, 1'b1, 32'h1236};
        tbl[4]  = '{6'b110000, 16'h0000, 5'b10000, 16'h0000, 1'b0, 32'h0};
        tbl[5]  = '{6'b110010, 16'h0000, 5'b00000, 16'h0000, 1'b0, 32'h0};
        tbl[6]  = '{6'b110000, 16'h0000, 5'b00000, 16'h0000, 1'b0, 32'h0};
        tbl[7]  = '{6'b110001, 16'hA000, 5'b00100, 16'hA000, 1'b0, 32'h0};
        for (int k = 1; k < BL; k++)
            tbl[7+k] = '{6'b100001, 16'hA000 + 16'(k), 5'b00000, 16'hA000 + 16'(k), 1'b0, 32'h0};
        tbl[15] = '{6'b100000, 16'h0000, 5'b00000, 16'hA007, 1'b0, 32'h0};
        tbl[16] = '{6'b100011, 16'hDEAD, 5'b00000, 16'hA007, 1'b0, 32'h0};

        step(); step();
        chk_reset_vals("reset");

        for (int i = 0; i < 17; i++) begin
            {reset_n, c0_req, c1_req, wr_req, sd_ack, sd_rdvalid} = tbl[i].in;
            sd_rdata = tbl[i].rdata;
            step();
            chk1("vec_sd_req", sd_req, tbl[i].ex[4]);
            chk1("vec_sd_we", sd_we, tbl[i].ex[3]);
            chk1("vec_c0_fill", c0_fill, tbl[i].ex[2]);
            chk1("vec_c1_fill", c1_fill, tbl[i].ex[1]);
            chk1("vec_wr_ack", wr_ack, tbl[i].ex[0]);
            chk16("vec_rd_data", rd_data, tbl[i].erd);
            if (tbl[i].chka) chk32("vec_sd_addr", sd_addr, tbl[i].eaddr);
        end
        sd_ack = 1'b0; sd_rdvalid = 1'b0; c0_req = 1'b0;

        // Round-robin: fresh reset so c0 wins the first contended grant
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        c0_req = 1'b1; c1_req = 1'b1;
        serve_read(1'b0, 32'h1236, 16'hB000);
        c0_req = 1'b1;
        serve_read(1'b1, 32'h2468, 16'hC000);
        serve_read(1'b0, 32'h1236, 16'hD000);

        // Write beats a pending read, then the read goes before a second write
        wr_addr = 32'h400; wr_data = 16'h55AA; wr_uds_n = 1'b1; wr_lds_n = 1'b0;
        wr_req = 1'b1; c1_req = 1'b1;
        wait_req("wr_grant");
        chk1("wr_we", sd_we, 1'b1);
        chk32("wr_addr", sd_addr, 32'h400);
        chk16("wr_wdata", sd_wdata, 16'h55AA);
        chk1("wr_uds_n", sd_uds_n, 1'b1);
        chk1("wr_lds_n", sd_lds_n, 1'b0);
        sd_ack = 1'b1;
        step();
        sd_ack = 1'b0;
        chk1("wr_ack", wr_ack, 1'b1);
        chk1("wr_req_drop", sd_req, 1'b0);
        wr_addr = 32'h402; wr_data = 16'h1111; wr_uds_n = 1'b0; wr_lds_n = 1'b0;
        step();
        chk1("wr_ack_once", wr_ack, 1'b0);
        serve_read(1'b1, 32'h2468, 16'hE000);

        wait_req("wr2_grant");
        chk1("wr2_we", sd_we, 1'b1);
        chk32("wr2_addr", sd_addr, 32'h402);
        chk16("wr2_wdata", sd_wdata, 16'h1111);
        chk1("wr2_uds_n", sd_uds_n, 1'b0);
        sd_ack = 1'b1;
        step();
        sd_ack = 1'b0;
        chk1("wr2_ack", wr_ack, 1'b1);
        step();
        wr_req = 1'b0;
        chk1("wr2_ack_once", wr_ack, 1'b0);
        step(); step();
        chk1("no_rewrite", sd_req, 1'b0);

        // Reset after the third burst word
        c0_req = 1'b1;
        wait_req("rst_grant");
        chk32("rst_addr", sd_addr, 32'h1236);
        sd_ack = 1'b1;
        step();
        sd_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sd_rdvalid = 1'b1;
            sd_rdata   = 16'h7000 + 16'(i);
            step();
            c0_req = 1'b0;
            chk16("pre_rst_data", rd_data, 16'h7000 + 16'(i));
        end
        reset_n = 1'b0;
        sd_rdata = 16'h7003;
        step();
        reset_n = 1'b1;
        chk_reset_vals("midrst");
        for (int i = 4; i < BL; i++) begin
            sd_rdata = 16'h7000 + 16'(i);
            step();
            chk1("disc_c0_fill", c0_fill, 1'b0);
            chk1("disc_c1_fill", c1_fill, 1'b0);
            chk16("disc_rd_data", rd_data, 16'h0000);
        end
        sd_rdvalid = 1'b0;
        c1_req = 1'b1;
        serve_read(1'b1, 32'h2468, 16'hF000);

        step(); step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_sdram_arbiter.md
# cache_sdram_arbiter

Shares the single SDRAM controller port between two two-way cache instances (fill requesters c0, c1) and the CPU write-through path. Read requests become critical-word-first burst fills returned to the granted cache. Write requests become single-word SDRAM writes with byte masks. Sits between the caches / CPU bus interface and the SDRAM controller.

## Interface
- BURST_LEN, 8, words per fill burst; power of two, 2..16
- ADDR_W, 32, address width on all address ports

- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- c0_req  in  1  cache 0 fill request, level; dropped by cache on c0_fill
- c0_addr  in  ADDR_W  cache 0 miss address (byte address, critical word)
- c0_fill  out  1  one-cycle strobe, first fill word valid on rd_data
- c1_req, c1_addr, c1_fill  as c0_* for cache 1
- rd_data  out  16  fill data to both caches, registered
- wr_req  in  1  CPU write request, level
- wr_addr  in  ADDR_W  write address
- wr_data  in  16  write data
- wr_uds_n, wr_lds_n  in  1 each  byte enables, active-low
- wr_ack  out  1  one-cycle pulse, write accepted by SDRAM
- sd_req  out  1  request to SDRAM controller
- sd_we  out  1  1 = write, 0 = burst read
- sd_addr  out  ADDR_W  SDRAM address
- sd_wdata  out  16  write data
- sd_uds_n, sd_lds_n  out  1 each  byte masks
- sd_ack  in  1  controller accepted current request, one-cycle pulse
- sd_rdvalid  in  1  one pulse per returned burst word, wrap order from sd_addr
- sd_rdata  in  16  burst read data

## Operation
- States: IDLE, RD_REQ, RD_DATA, WR_REQ, DONE.
- IDLE:
  - Grant one pending requester. Latch its address, plus data and masks for writes.
  - Write-then-read fairness flag wprio:
    - wprio=1: write beats reads.
    - wprio=0: a pending read beats a write.
    - wprio toggles after every completed transaction of the other class.
  - Between c0 and c1: round-robin via last_rd; the cache not served last wins. Reset last_rd=1, so c0 wins first.
  - Read grant goes to RD_REQ; write grant goes to WR_REQ; nothing pending stays in IDLE.
- RD_REQ:
  - Drive sd_req=1, sd_we=0, sd_addr = latched client address unmodified.
  - On sd_ack, go to RD_DATA with word counter cnt=0.
- RD_DATA:
  - Each sd_rdvalid: rd_data <= sd_rdata, and cnt increments.
  - On the first word (cnt==0), also pulse the granted client's fill strobe, aligned with that rd_data.
  - After the BURST_LEN-th word, go to DONE.
  - Words must arrive on consecutive cycles, because the cache samples blindly after fill. A gap is a controller protocol violation. The arbiter still counts only sd_rdvalid pulses.
- WR_REQ:
  - Drive sd_req=1, sd_we=1, sd_addr/sd_wdata/masks from latches.
  - On sd_ack, pulse wr_ack and go to DONE.
- DONE:
  - One recovery cycle. Requests are ignored so a slow-dropping level request is not re-granted.
  - Go to IDLE.
- sd_rdvalid outside RD_DATA is ignored. sd_ack outside RD_REQ/WR_REQ is ignored.
- Requests asserted during a transaction are held pending (level inputs) and arbitrated in IDLE.
- Reset, including mid-burst or mid-write:
  - Go to IDLE; wprio=1; last_rd=1; cnt=0.
  - Remaining burst words are discarded.

## Timing
- Reset values: sd_req=0, sd_we=0, sd_addr=0, sd_wdata=0, sd_uds_n=1, sd_lds_n=1, c0_fill=0, c1_fill=0, wr_ack=0, rd_data=0.
- All outputs registered.
- sd_req rises 1 cycle after a request is sampled in IDLE.
- sd_req falls in the cycle after sd_ack is sampled high. The controller must tolerate sd_req high during the ack cycle.
- cN_fill and the first rd_data appear 1 cycle after the first sd_rdvalid. Words 2..BURST_LEN follow on the next BURST_LEN-1 cycles.
- wr_ack is high the cycle after sd_ack.
- Minimum read occupancy: 1 (IDLE) + 1 (req) + ack latency + BURST_LEN + 1 (DONE) cycles. A back-to-back grant is possible 1 cycle after DONE.

## Test plan
- c0 read at 0x1236, controller acks 3 cycles later, returns 8 words 0xA000+i starting at word 3:
  - sd_addr=0x1236, sd_we=0.
  - c0_fill pulses once with rd_data=0xA000, then 0xA001..0xA007 on consecutive cycles.
  - c1_fill stays 0.
- c0 and c1 request in the same cycle, held:
  - c0 is served first, then c1, then c0 again if it re-requests.
  - Each fill strobe goes only to the granted client.
- Write 0x55AA to 0x400 with wr_lds_n=0, wr_uds_n=1, while c1 also requests:
  - Write goes first: sd_we=1, sd_uds_n=1, sd_lds_n=0, wr_ack pulses once.
  - c1 read follows next, even with a second write pending.
  - wr_req held high through DONE produces no second write.
- reset_n low for 1 cycle after the 3rd burst word:
  - All outputs return to reset values next cycle.
  - Remaining sd_rdvalid pulses produce no fill or rd_data change.
  - A new c1 request is then granted normally.
- Spurious sd_rdvalid and sd_ack in IDLE:
  - No fill, no wr_ack, and rd_data is unchanged (0).
